// File: rtl/regfile_pkg.sv
// Shared constants and slicing helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;

    // Address width for a register count; at least one bit so a 2-entry file still decodes.
    function automatic int addr_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 8; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

    // Low bit of field idx in a flat bus of w-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservation beats writeback, flush beats both, x0 never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    parameter int AW   = addr_w(NREG_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NWR-1:0]     wr_en_i,
    input  logic [NWR*AW-1:0]  wr_addr_i,
    input  logic               rsv_en_i,
    input  logic [AW-1:0]      rsv_addr_i,
    input  logic               flush_i,
    output logic [NREG-1:0]    busy_o,
    output logic [AW:0]        busy_cnt_o
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++)
            if (wr_en_i[w] && wr_addr_i[slice_lo(w, AW) +: AW] != '0)
                busy_d[wr_addr_i[slice_lo(w, AW) +: AW]] = 1'b0;
        if (rsv_en_i && rsv_addr_i != '0)
            busy_d[rsv_addr_i] = 1'b1;
        if (flush_i)
            busy_d = '0;
        busy_d[0] = 1'b0;
    end

    // Count the next state so the registered count matches busy after every edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writebacks to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = addr_w(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy;

    regfile_scoreboard #(.NREG(NREG), .NWR(NWR), .AW(AW)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt)
    );

    // Later ports are visited last, so the highest-numbered port wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[slice_lo(w, AW) +: AW] != '0)
                    regs_q[wr_addr[slice_lo(w, AW) +: AW]] <= wr_data[slice_lo(w, XLEN) +: XLEN];
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbsy;
`ifdef REGFILE_SB_BYPASS_EN
        logic            fwd;
        logic [XLEN-1:0] fdat;
`endif

        assign ra = rd_addr[slice_lo(p, AW) +: AW];

        always_comb begin
            rdat = regs_q[ra];
            rbsy = busy[ra];
`ifdef REGFILE_SB_BYPASS_EN
            fwd  = 1'b0;
            fdat = '0;
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[slice_lo(w, AW) +: AW] == ra) begin
                    fwd  = 1'b1;
                    fdat = wr_data[slice_lo(w, XLEN) +: XLEN];
                end
            // A same-cycle reservation of this register means the value is still in flight.
            if (fwd && ra != '0 && !(rsv_en && rsv_addr == ra)) begin
                rdat = fdat;
                rbsy = 1'b0;
            end
`endif
            if (!rst_n) begin
                rdat = '0;
                rbsy = 1'b0;
            end
        end

        assign rd_data[slice_lo(p, XLEN) +: XLEN] = rdat;
        assign rd_busy[p] = rbsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb at default parameters (XLEN 64, 32 regs, 2R/2W).
module tb_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic              clk;
    logic              rst_n;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              flush;
    logic [AW:0]       busy_cnt;

    int checks;
    int errors;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_addr = '0;
        flush   = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = {5'd7, 5'd0};
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", busy_cnt);
        end
        rst_n = 1'b1;
        for (int a = 0; a < NREG / 2; a++) begin
            rd_addr = {5'(a + 16), 5'(a)};
            #1;
            checks++;
            if (rd_data !== '0 || rd_busy !== 2'b00) begin
                errors++; $display("FAIL reset_read a=%0d got %h/%b want 0/0", a, rd_data, rd_busy);
            end
        end
        checks++;
        if (busy_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt_rel got %0d want 0", busy_cnt);
        end
        tick();
    endtask

    task automatic test_rsv_write();
        rd_addr = {5'd0, 5'd5};
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle();
        checks++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL rsv5 got busy=%b cnt=%0d want 1/1", rd_busy[0], busy_cnt);
        end
        tick();
        checks++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL rsv5_hold got busy=%b cnt=%0d want 1/1", rd_busy[0], busy_cnt);
        end
        wr_en = 2'b10; wr_addr = {5'd5, 5'd0}; wr_data = {64'hDEAD, 64'h0};
        tick();
        idle();
        checks++;
        if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || rd_data[63:0] !== 64'hDEAD) begin
            errors++; $display("FAIL wr5 got busy=%b cnt=%0d data=%h want 0/0/dead", rd_busy[0], busy_cnt, rd_data[63:0]);
        end
    endtask

    task automatic test_multi_write();
        rd_addr = {5'd0, 5'd7};
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {64'h22, 64'h11};
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle();
        checks++;
        if (rd_data[63:0] !== 64'h22) begin
            errors++; $display("FAIL multi_wr data got %h want 22", rd_data[63:0]);
        end
        checks++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL multi_wr busy got %b cnt=%0d want 1/1", rd_busy[0], busy_cnt);
        end
    endtask

    task automatic test_x0();
        rd_addr = {5'd0, 5'd0};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {64'h0, 64'hFF};
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        checks++;
        if (rd_data[63:0] !== 64'h0 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL x0 got data=%h busy=%b cnt=%0d want 0/0/1", rd_data[63:0], rd_busy[0], busy_cnt);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) begin
            rsv_en = 1'b1; rsv_addr = 5'(r);
            tick();
        end
        idle();
        checks++;
        if (busy_cnt !== 6'd5) begin
            errors++; $display("FAIL pre_flush cnt got %0d want 5", busy_cnt);
        end
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd9;
        rd_addr = {5'd7, 5'd9};
        tick();
        idle();
        checks++;
        if (busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
            errors++; $display("FAIL flush got cnt=%0d busy=%b want 0/00", busy_cnt, rd_busy);
        end
    endtask

    task automatic test_bypass();
        rd_addr = {5'd0, 5'd3};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {64'h0, 64'h42};
        #1;
        checks++;
`ifdef REGFILE_SB_BYPASS_EN
        if (rd_data[63:0] !== 64'h42) begin
            errors++; $display("FAIL bypass_same got %h want 42", rd_data[63:0]);
        end
`else
        if (rd_data[63:0] !== 64'h0) begin
            errors++; $display("FAIL nobypass_same got %h want 0", rd_data[63:0]);
        end
`endif
        tick();
        idle();
        checks++;
        if (rd_data[63:0] !== 64'h42) begin
            errors++; $display("FAIL bypass_next got %h want 42", rd_data[63:0]);
        end
    endtask

    task automatic test_wr_rsv_same();
        rd_addr = {5'd12, 5'd12};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {64'h0, 64'h1234};
        rsv_en = 1'b1; rsv_addr = 5'd12;
        tick();
        idle();
        checks++;
        if (rd_busy !== 2'b11 || rd_data[63:0] !== 64'h1234 || busy_cnt !== 6'd1) begin
            errors++; $display("FAIL wr_rsv got busy=%b data=%h cnt=%0d want 11/1234/1", rd_busy, rd_data[63:0], busy_cnt);
        end
    endtask

    task automatic test_async_reset();
        rd_addr = {5'd12, 5'd3};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = {64'h0, 64'hBEEF};
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL async_rst got data=%h busy=%b cnt=%0d want 0", rd_data, rd_busy, busy_cnt);
        end
        idle();
        tick();
        rst_n = 1'b1;
        rd_addr = {5'd12, 5'd20};
        tick();
        checks++;
        if (rd_data !== '0 || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL post_rst got data=%h cnt=%0d want 0", rd_data, busy_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rsv_write();
        test_multi_write();
        test_x0();
        test_flush();
        test_bypass();
        test_wr_rsv_same();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
